prime_checker_seq: RTL and testbench



---
 rtl/prime_checker_seq_if.sv | 21 ++
 rtl/prime_checker_seq.sv | 152 +++++++++++++++
 tb/tb_prime_checker_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/prime_checker_seq_if.sv
// Handshake bundle for the sequential primality tester.
//   start    : request pulse from the requester
//   number   : WIDTH-bit unsigned operand, captured on the accepted start
//   busy     : checker is working (high in every state except idle)
//   done     : one-cycle pulse, results valid from this cycle on
//   is_prime : 1 when the operand is prime
//   factor   : smallest divisor > 1 when composite, 0 otherwise
// master = requester side, slave = checker side.
interface prime_checker_seq_if #(
  parameter int WIDTH = 9
) ();
  logic             start;
  logic [WIDTH-1:0] number;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic [WIDTH-1:0] factor;

  modport master (output start, number, input busy, done, is_prime, factor);
  modport slave  (input start, number, output busy, done, is_prime, factor);
endinterface

// File: rtl/prime_checker_seq.sv
// Sequential primality tester using odd trial division.
// Each trial divisor d is checked with a bit-serial restoring remainder unit,
// one operand bit per cycle, MSB first. Trials stop at the first divisor
// that leaves remainder 0, or as soon as d*d exceeds the operand.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any operation, no done)
//   bus : slave side of prime_checker_seq_if (start/number in,
//         busy/done/is_prime/factor out, all outputs registered)
module prime_checker_seq #(
  parameter int WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  prime_checker_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_TEST,
    S_DIV,
    S_EVAL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;          // latched operand
  logic [WIDTH:0]   d_q, d_d;          // current odd trial divisor
  logic [WIDTH:0]   rem_q, rem_d;      // running remainder
  logic [WIDTH-1:0] shift_q, shift_d;  // operand bits still to be shifted in
  logic [CW-1:0]    cnt_q, cnt_d;      // division steps left minus one
  logic             is_prime_q, is_prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;

  logic [PW-1:0]    d_wide, n_wide, d_sq;
  logic [WIDTH:0]   rem_shift, rem_sub;

  // d*d at double width never overflows for any reachable divisor.
  assign d_wide    = PW'(d_q);
  assign n_wide    = PW'(n_q);
  assign d_sq      = d_wide * d_wide;
  // One restoring step: bring down the next operand bit, then conditionally subtract.
  assign rem_shift = {rem_q[WIDTH-1:0], shift_q[WIDTH-1]};
  assign rem_sub   = rem_shift - d_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case can leave it unassigned, which would infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    d_d        = d_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    is_prime_d = is_prime_q;
    factor_d   = factor_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = bus.number;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (n_q < WIDTH'(2)) begin
          is_prime_d = 1'b0;
          factor_d   = '0;
          state_d    = S_DONE;
        end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
          is_prime_d = 1'b1;
          factor_d   = '0;
          state_d    = S_DONE;
        end else if (!n_q[0]) begin
          is_prime_d = 1'b0;
          factor_d   = WIDTH'(2);
          state_d    = S_DONE;
        end else begin
          d_d     = (WIDTH + 1)'(3);
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        if (d_sq > n_wide) begin
          is_prime_d = 1'b1;
          factor_d   = '0;
          state_d    = S_DONE;
        end else begin
          rem_d   = '0;
          shift_d = n_q;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        shift_d = shift_q << 1;
        rem_d   = (rem_shift >= d_q) ? rem_sub : rem_shift;
        if (cnt_q == '0) state_d = S_EVAL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_EVAL: begin
        if (rem_q == '0) begin
          is_prime_d = 1'b0;
          factor_d   = d_q[WIDTH-1:0];
          state_d    = S_DONE;
        end else begin
          d_d     = d_q + (WIDTH + 1)'(2);
          state_d = S_TEST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, datapath
    // included, so an aborted operation leaves nothing stale behind.
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      d_q        <= '0;
      rem_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      is_prime_q <= 1'b0;
      factor_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      d_q        <= d_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      is_prime_q <= is_prime_d;
      factor_q   <= factor_d;
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.is_prime = is_prime_q;
  assign bus.factor   = factor_q;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Self-checking bench for prime_checker_seq at WIDTH=9 and WIDTH=12.
// Expected results are pushed to a scoreboard queue when an operation is
// started and popped when the design raises done. Latency is counted in
// clock edges after the accepting edge k; done "at cycle k+L" means done is
// observed high just after edge k+L-1.
module tb_prime_checker_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prime_checker_seq_if #(.WIDTH(9))  bus9  ();
  prime_checker_seq_if #(.WIDTH(12)) bus12 ();

  prime_checker_seq #(.WIDTH(9))  dut9  (.clk(clk), .rst(rst), .bus(bus9));
  prime_checker_seq #(.WIDTH(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  typedef struct {
    logic        prime;
    logic [11:0] factor;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input bit wide);
    return wide ? bus12.done : bus9.done;
  endfunction
  function automatic logic get_busy(input bit wide);
    return wide ? bus12.busy : bus9.busy;
  endfunction
  function automatic logic get_prime(input bit wide);
    return wide ? bus12.is_prime : bus9.is_prime;
  endfunction
  function automatic logic [11:0] get_factor(input bit wide);
    return wide ? bus12.factor : 12'(bus9.factor);
  endfunction

  task automatic set_in(input bit wide, input logic s, input int n);
    if (wide) begin
      bus12.start  = s;
      bus12.number = 12'(n);
    end else begin
      bus9.start  = s;
      bus9.number = 9'(n);
    end
  endtask

  // Independent reference: plain modulo trial division plus the latency rule.
  task automatic model(input int n, input int w, output logic p, output int f, output int lat);
    int d, t;
    if (n < 2)                 begin p = 1'b0; f = 0; lat = 2; end
    else if (n == 2 || n == 3) begin p = 1'b1; f = 0; lat = 2; end
    else if (n % 2 == 0)       begin p = 1'b0; f = 2; lat = 2; end
    else begin
      d = 3; t = 0;
      forever begin
        if (d * d > n) begin p = 1'b1; f = 0; lat = 3 + t * (w + 2); break; end
        t++;
        if (n % d == 0) begin p = 1'b0; f = d; lat = 2 + t * (w + 2); break; end
        d += 2;
      end
    end
  endtask

  // Called at a negedge after the accepting edge; m = edges until done seen.
  task automatic wait_done(input bit wide, input int budget, output int m, output bit ok);
    m = 0; ok = 1'b0;
    while (m < budget && !ok) begin
      @(posedge clk);
      m++;
      @(negedge clk);
      if (get_done(wide)) ok = 1'b1;
    end
  endtask

  task automatic finish_op(input bit wide, input string tag, input int m, input bit ok);
    exp_t e;
    e = sb.pop_front();
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, " is_prime"}, 32'(get_prime(wide)), 32'(e.prime));
      check({tag, " factor"},   32'(get_factor(wide)), 32'(e.factor));
      check({tag, " latency"},  32'(m + 1), 32'(e.lat));
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Start an op in IDLE (called at a negedge), wait for it, return to IDLE.
  task automatic run_op(input bit wide, input int n, input logic ep, input int ef,
                        input int el, input string tag);
    int m; bit ok;
    set_in(wide, 1'b1, n);
    sb.push_back('{prime: ep, factor: 12'(ef), lat: el});
    @(posedge clk);
    @(negedge clk);
    set_in(wide, 1'b0, n);
    wait_done(wide, 1000, m, ok);
    finish_op(wide, tag, m, ok);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(get_done(wide)), 32'd0);
  endtask

  task automatic sweep_one(input bit wide, input int n);
    logic p; int f, lat, w;
    w = wide ? 12 : 9;
    model(n, w, p, f, lat);
    run_op(wide, n, p, f, lat, $sformatf("w%0d n=%0d", w, n));
  endtask

  initial begin
    int m, dcount;
    bit ok;
    set_in(1'b0, 1'b0, 0);
    set_in(1'b1, 1'b0, 0);

    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy",     32'(bus9.busy),     32'd0);
    check("rst done",     32'(bus9.done),     32'd0);
    check("rst is_prime", 32'(bus9.is_prime), 32'd0);
    check("rst factor",   32'(bus9.factor),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Trivial operands and small primes.
    run_op(1'b0, 0,   1'b0, 0,  2,   "n0");
    run_op(1'b0, 1,   1'b0, 0,  2,   "n1");
    run_op(1'b0, 2,   1'b1, 0,  2,   "n2");
    run_op(1'b0, 3,   1'b1, 0,  2,   "n3");
    run_op(1'b0, 4,   1'b0, 2,  2,   "n4");
    run_op(1'b0, 5,   1'b1, 0,  3,   "n5");
    run_op(1'b0, 11,  1'b1, 0,  14,  "n11");
    run_op(1'b0, 359, 1'b1, 0,  91,  "n359");
    run_op(1'b0, 511, 1'b0, 7,  35,  "n511");
    run_op(1'b0, 361, 1'b0, 19, 101, "n361");

    // Handshake: start pulsed with 9, then held high with number=7.
    set_in(1'b0, 1'b1, 9);
    sb.push_back('{prime: 1'b0, factor: 12'd3, lat: 13});
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b1, 7);
    wait_done(1'b0, 1000, m, ok);
    finish_op(1'b0, "hs n9", m, ok);
    @(negedge clk);  // in IDLE: start seen in DONE was ignored
    check("hs idle busy",   32'(bus9.busy),     32'd0);
    check("hs idle done",   32'(bus9.done),     32'd0);
    check("hs hold factor", 32'(bus9.factor),   32'd3);
    check("hs hold prime",  32'(bus9.is_prime), 32'd0);
    sb.push_back('{prime: 1'b1, factor: 12'd0, lat: 3});
    @(posedge clk);  // held start accepted here
    @(negedge clk);
    check("hs accept busy", 32'(bus9.busy), 32'd1);
    set_in(1'b0, 1'b0, 7);
    wait_done(1'b0, 1000, m, ok);
    finish_op(1'b0, "hs n7", m, ok);
    repeat (4) @(negedge clk);
    check("hs hold2 prime",  32'(bus9.is_prime), 32'd1);
    check("hs hold2 factor", 32'(bus9.factor),   32'd0);
    check("hs hold2 done",   32'(bus9.done),     32'd0);

    // Reset in the middle of a division.
    set_in(1'b0, 1'b1, 359);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 359);
    repeat (19) @(negedge clk);
    check("mid busy before rst", 32'(bus9.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst busy",     32'(bus9.busy),     32'd0);
    check("mid rst done",     32'(bus9.done),     32'd0);
    check("mid rst is_prime", 32'(bus9.is_prime), 32'd0);
    check("mid rst factor",   32'(bus9.factor),   32'd0);
    rst = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus9.done) dcount++;
    end
    check("mid no done", 32'(dcount), 32'd0);
    run_op(1'b0, 9, 1'b0, 3, 13, "after rst n9");

    // Full sweep at WIDTH=9; ends of the range at WIDTH=12.
    for (int n = 0; n < 512; n++) sweep_one(1'b0, n);
    for (int n = 0; n < 200; n++) sweep_one(1'b1, n);
    for (int n = 3896; n < 4096; n++) sweep_one(1'b1, n);
    repeat (20) sweep_one(1'b1, int'($urandom_range(200, 3895)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
